// File: rtl/sr_dbg_dump.sv
// Debug register dump: streams a sync byte, then debug registers FIRST_REG..LAST_REG
// as little-endian bytes over a valid/ready byte interface.
module sr_dbg_dump #(
  parameter int          FIRST_REG = 0,
  parameter int          LAST_REG  = 31,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SYNC, LOAD, SEND, DONE} state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= FIRST_IDX;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // txValid is high only in SYNC/SEND, so txReady alone qualifies a transfer there
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        idx_d = FIRST_IDX;
        if (start) state_d = SYNC;
      end
      SYNC: if (txReady) state_d = LOAD;
      LOAD: begin
        shift_d = regData;
        cnt_d   = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (txReady) begin
          if (cnt_q != 2'd3) begin
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q + 2'd1;
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        idx_d   = FIRST_IDX;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing combinational from start/txReady
  always_comb begin
    txValid = 1'b0;
    txData  = 8'h00;
    unique case (state_q)
      SYNC: begin
        txValid = 1'b1;
        txData  = SYNC_BYTE;
      end
      SEND: begin
        txValid = 1'b1;
        txData  = shift_q[7:0];
      end
      default: ;
    endcase
  end

  assign regAddr = idx_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_sr_dbg_dump.sv
// Directed bench for sr_dbg_dump: default 32-register dump plus a single-register instance.
module tb_sr_dbg_dump;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady = 1'b0;
  logic        busy, done;
  logic [31:0] xor_mask = 32'h0;

  logic        start5 = 1'b0;
  logic [4:0]  regAddr5;
  logic [31:0] regData5;
  logic [7:0]  txData5;
  logic        txValid5;
  logic        txReady5 = 1'b0;
  logic        busy5, done5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got [0:255];
  int got_n, done_cnt, done_cyc, stall_bad;
  bit timed_out;

  always #5 clk = ~clk;

  function automatic logic [31:0] model_rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0000_0040 : 32'h1000_0000 + 32'(a);
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    logic [31:0] v;
    int r, b;
    if (k == 0) return 8'hA5;
    r = (k - 1) / 4;
    b = (k - 1) % 4;
    v = model_rf(5'(r));
    return v[8*b +: 8];
  endfunction

  assign regData  = model_rf(regAddr) ^ xor_mask;
  assign regData5 = (regAddr5 == 5'd5) ? 32'hDEAD_BEEF : (32'h0BAD_0000 | 32'(regAddr5));

  sr_dbg_dump dut (
    .clk(clk), .reset(reset), .start(start), .regAddr(regAddr), .regData(regData),
    .txData(txData), .txValid(txValid), .txReady(txReady), .busy(busy), .done(done)
  );

  sr_dbg_dump #(.FIRST_REG(5), .LAST_REG(5), .SYNC_BYTE(8'hA5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .regAddr(regAddr5), .regData(regData5),
    .txData(txData5), .txValid(txValid5), .txReady(txReady5), .busy(busy5), .done(done5)
  );

  // Starts a frame on the default instance and records accepted bytes, done pulses and stall violations.
  task automatic collect(input int pct, input bit scr, input int maxc);
    bit stalled;
    logic [7:0] pd;
    got_n = 0; done_cnt = 0; done_cyc = -1; stall_bad = 0; timed_out = 1'b1;
    stalled = 1'b0; pd = 8'h00;
    @(negedge clk); start = 1'b1; txReady = 1'b1;
    for (int cyc = 1; cyc <= maxc; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (stalled && (txValid !== 1'b1 || txData !== pd)) stall_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      xor_mask = (scr && txValid === 1'b1) ? $urandom() : 32'h0;
      txReady = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      if (txValid === 1'b1 && txReady && got_n < 256) begin
        got[got_n] = txData;
        got_n++;
      end
      stalled = (txValid === 1'b1) && !txReady;
      pd = txData;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    xor_mask = 32'h0;
    txReady = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk);
    n_checks++; if (txValid !== 1'b0) begin n_fail++; $display("FAIL reset_txValid got %b want 0", txValid); end
    n_checks++; if (txData !== 8'h00) begin n_fail++; $display("FAIL reset_txData got %h want 00", txData); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (regAddr !== 5'd0) begin n_fail++; $display("FAIL reset_regAddr got %0d want 0", regAddr); end
    n_checks++; if (regAddr5 !== 5'd5) begin n_fail++; $display("FAIL reset_regAddr5 got %0d want 5", regAddr5); end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_with_reset busy got %b want 0", busy); end
  endtask

  task automatic test_full_frame;
    collect(100, 1'b0, 400);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL full_timeout got no done want done"); end
    n_checks++; if (got_n !== 129) begin n_fail++; $display("FAIL full_len got %0d want 129", got_n); end
    n_checks++; if (done_cyc !== 162) begin n_fail++; $display("FAIL full_latency got %0d want 162", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
    for (int k = 0; k < got_n && k < 129; k++) begin
      n_checks++;
      if (got[k] !== exp_byte(k)) begin n_fail++; $display("FAIL full_byte[%0d] got %h want %h", k, got[k], exp_byte(k)); end
    end
    n_checks++; if (regAddr !== 5'd0) begin n_fail++; $display("FAIL full_idle_regAddr got %0d want 0", regAddr); end
  endtask

  task automatic test_backpressure;
    collect(30, 1'b0, 3000);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout got no done want done"); end
    n_checks++; if (got_n !== 129) begin n_fail++; $display("FAIL bp_len got %0d want 129", got_n); end
    n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stall_hold got %0d violations want 0", stall_bad); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
    for (int k = 0; k < got_n && k < 129; k++) begin
      n_checks++;
      if (got[k] !== exp_byte(k)) begin n_fail++; $display("FAIL bp_byte[%0d] got %h want %h", k, got[k], exp_byte(k)); end
    end
  endtask

  task automatic test_reset_midframe;
    int n;
    n = 0;
    @(negedge clk); start = 1'b1; txReady = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); start = 1'b0;
      if (txValid === 1'b1) n++;
      if (n == 10) break;
    end
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL mid_xfers got %0d want 10", n); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_checks++; if (txValid !== 1'b0) begin n_fail++; $display("FAIL mid_txValid got %b want 0", txValid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    n_checks++; if (regAddr !== 5'd0) begin n_fail++; $display("FAIL mid_regAddr got %0d want 0", regAddr); end
    n_checks++; if (txData !== 8'h00) begin n_fail++; $display("FAIL mid_txData got %h want 00", txData); end
    reset = 1'b0; txReady = 1'b0;
    collect(100, 1'b0, 400);
    n_checks++; if (got_n !== 129) begin n_fail++; $display("FAIL mid_restart_len got %0d want 129", got_n); end
    n_checks++; if (got[0] !== 8'hA5) begin n_fail++; $display("FAIL mid_restart_sync got %h want a5", got[0]); end
    n_checks++; if (got[1] !== 8'h40) begin n_fail++; $display("FAIL mid_restart_pc got %h want 40", got[1]); end
    n_checks++; if (done_cyc !== 162) begin n_fail++; $display("FAIL mid_restart_latency got %0d want 162", done_cyc); end
  endtask

  task automatic test_single_reg;
    logic [7:0] b5 [0:7];
    logic [7:0] want [0:4];
    int nb, dc;
    want[0] = 8'hA5; want[1] = 8'hEF; want[2] = 8'hBE; want[3] = 8'hAD; want[4] = 8'hDE;
    nb = 0; dc = -1;
    @(negedge clk); start5 = 1'b1; txReady5 = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk); start5 = 1'b0;
      if (done5 === 1'b1 && dc < 0) dc = cyc;
      if (txValid5 === 1'b1 && nb < 8) begin b5[nb] = txData5; nb++; end
    end
    n_checks++; if (nb !== 5) begin n_fail++; $display("FAIL single_len got %0d want 5", nb); end
    n_checks++; if (dc !== 7) begin n_fail++; $display("FAIL single_latency got %0d want 7", dc); end
    for (int k = 0; k < 5 && k < nb; k++) begin
      n_checks++;
      if (b5[k] !== want[k]) begin n_fail++; $display("FAIL single_byte[%0d] got %h want %h", k, b5[k], want[k]); end
    end
    n_checks++; if (regAddr5 !== 5'd5) begin n_fail++; $display("FAIL single_idle_regAddr got %0d want 5", regAddr5); end
    txReady5 = 1'b0;
  endtask

  task automatic test_back_to_back;
    int d1, d2, lowcnt, nx;
    logic [7:0] fb;
    logic fv;
    d1 = -1; d2 = -1; lowcnt = 0; nx = 0; fb = 8'h00; fv = 1'b0;
    @(negedge clk); start = 1'b1; txReady = 1'b1;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
      if (d1 < 0 && txValid === 1'b1) nx++;
      if (d1 >= 0 && cyc > d1 && d2 < 0 && busy === 1'b0) lowcnt++;
      if (d1 >= 0 && cyc == d1 + 2) begin
        fb = txData; fv = txValid; start = 1'b0;
      end
      if (d2 >= 0 && cyc >= d2 + 2) break;
    end
    start = 1'b0; txReady = 1'b0;
    n_checks++; if (d1 !== 162) begin n_fail++; $display("FAIL b2b_first_done got %0d want 162", d1); end
    n_checks++; if (nx !== 129) begin n_fail++; $display("FAIL b2b_first_len got %0d want 129", nx); end
    n_checks++; if (lowcnt !== 1) begin n_fail++; $display("FAIL b2b_idle_gap got %0d want 1", lowcnt); end
    n_checks++; if (fv !== 1'b1 || fb !== 8'hA5) begin n_fail++; $display("FAIL b2b_second_sync got %b/%h want 1/a5", fv, fb); end
    n_checks++; if (d2 !== 325) begin n_fail++; $display("FAIL b2b_second_done got %0d want 325", d2); end
  endtask

  task automatic test_capture;
    collect(100, 1'b1, 400);
    n_checks++; if (got_n !== 129) begin n_fail++; $display("FAIL cap_len got %0d want 129", got_n); end
    for (int k = 0; k < got_n && k < 129; k++) begin
      n_checks++;
      if (got[k] !== exp_byte(k)) begin n_fail++; $display("FAIL cap_byte[%0d] got %h want %h", k, got[k], exp_byte(k)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_full_frame();
    test_backpressure();
    test_reset_midframe();
    test_single_reg();
    test_back_to_back();
    test_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
